// File: rtl/param_reg_file_if.sv
// Bus bundle for param_reg_file: read/write/increment/clear selects, data in/out,
// sticky error flags and per-register wrap pulses.
interface param_reg_file_if #(
  parameter int unsigned REG_COUNT = 11,
  parameter int unsigned REG_WIDTH = 12
);
  logic [REG_COUNT-1:0] read_en;
  logic [REG_COUNT-1:0] write_en;
  logic [REG_COUNT-1:0] inc_en;
  logic [REG_COUNT-1:0] clr_en;
  logic [REG_WIDTH-1:0] datain;
  logic                 err_clr;
  logic [REG_WIDTH-1:0] dataout;
  logic [REG_COUNT-1:0] wrap;
  logic                 rd_err;
  logic                 wr_err;

  modport master (
    output read_en, write_en, inc_en, clr_en, datain, err_clr,
    input  dataout, wrap, rd_err, wr_err
  );

  modport slave (
    input  read_en, write_en, inc_en, clr_en, datain, err_clr,
    output dataout, wrap, rd_err, wr_err
  );
endinterface

// File: rtl/param_reg_file.sv
// Parametrised register bank with per-register write/clear/increment, one-hot read mux
// and sticky detection of multi-hot read/write selects.
module param_reg_file #(
  parameter int unsigned                       REG_COUNT   = 11,
  parameter int unsigned                       REG_WIDTH   = 12,
  parameter logic [REG_COUNT*REG_WIDTH-1:0]    RESET_VEC   = '0,
  parameter int unsigned                       DEFAULT_IDX = 8,
  parameter bit                                BYPASS      = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  param_reg_file_if.slave    bus
);

  localparam int unsigned IDXW = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

  logic [REG_WIDTH-1:0] regs [REG_COUNT];
  logic [REG_COUNT-1:0] wr_sel;
  logic                 wr_multi;
  logic                 rd_multi;
  logic                 rd_onehot;
  logic [REG_WIDTH-1:0] dout;
  logic [REG_COUNT-1:0] wrap_q;
  logic                 rd_err_q;
  logic                 wr_err_q;

  // x & -x isolates the lowest set bit; x & (x-1) is nonzero only when multi-hot
  assign wr_sel    = bus.write_en & (~bus.write_en + REG_COUNT'(1));
  assign wr_multi  = |(bus.write_en & (bus.write_en - REG_COUNT'(1)));
  assign rd_multi  = |(bus.read_en & (bus.read_en - REG_COUNT'(1)));
  assign rd_onehot = (|bus.read_en) & ~rd_multi;

  // Read mux; idle or invalid selects fall back to the default register
  always_comb begin
    dout = regs[IDXW'(DEFAULT_IDX)];
    if (rd_onehot) begin
      for (int i = 0; i < int'(REG_COUNT); i++) begin
        if (bus.read_en[i]) begin
          dout = (BYPASS && wr_sel[i]) ? bus.datain : regs[i];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(REG_COUNT); i++) begin
        regs[i] <= RESET_VEC[i*REG_WIDTH +: REG_WIDTH];
      end
      wrap_q   <= '0;
      rd_err_q <= 1'b0;
      wr_err_q <= 1'b0;
    end else begin
      for (int i = 0; i < int'(REG_COUNT); i++) begin
        wrap_q[i] <= 1'b0;
        if (bus.clr_en[i]) begin
          regs[i] <= '0;
        end else if (wr_sel[i]) begin
          regs[i] <= bus.datain;
        end else if (bus.inc_en[i]) begin
          regs[i]   <= regs[i] + REG_WIDTH'(1);
          wrap_q[i] <= &regs[i];
        end
      end
      // New error wins over a simultaneous clear
      rd_err_q <= rd_multi | (rd_err_q & ~bus.err_clr);
      wr_err_q <= wr_multi | (wr_err_q & ~bus.err_clr);
    end
  end

  assign bus.dataout = dout;
  assign bus.wrap    = wrap_q;
  assign bus.rd_err  = rd_err_q;
  assign bus.wr_err  = wr_err_q;

endmodule

// File: tb/tb_param_reg_file.sv
// Directed self-checking bench for param_reg_file; a BYPASS=0 and a BYPASS=1 instance
// receive identical stimulus.
module tb_param_reg_file;

  localparam int unsigned RC = 11;
  localparam int unsigned RW = 12;
  localparam logic [RC*RW-1:0] RV = ((RC*RW)'(1600) << (9*RW)) | ((RC*RW)'(900) << (8*RW));

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  param_reg_file_if #(.REG_COUNT(RC), .REG_WIDTH(RW)) bus0 ();
  param_reg_file_if #(.REG_COUNT(RC), .REG_WIDTH(RW)) bus1 ();

  param_reg_file #(.REG_COUNT(RC), .REG_WIDTH(RW), .RESET_VEC(RV),
                   .DEFAULT_IDX(8), .BYPASS(1'b0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0));

  param_reg_file #(.REG_COUNT(RC), .REG_WIDTH(RW), .RESET_VEC(RV),
                   .DEFAULT_IDX(8), .BYPASS(1'b1)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [RC-1:0] rd, input logic [RC-1:0] wr,
                       input logic [RC-1:0] inc, input logic [RC-1:0] clr,
                       input logic [RW-1:0] din, input logic ec);
    bus0.read_en = rd;  bus1.read_en = rd;
    bus0.write_en = wr; bus1.write_en = wr;
    bus0.inc_en = inc;  bus1.inc_en = inc;
    bus0.clr_en = clr;  bus1.clr_en = clr;
    bus0.datain = din;  bus1.datain = din;
    bus0.err_clr = ec;  bus1.err_clr = ec;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [RC-1:0] bit_of(input int idx);
    return RC'(1) << idx;
  endfunction

  // Read one register via a one-hot select with all updates idle
  task automatic read_chk(input string tag, input int idx, input logic [RW-1:0] exp);
    drive(bit_of(idx), '0, '0, '0, '0, 1'b0);
    #1;
    check(tag, 32'(bus0.dataout), 32'(exp));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    drive('0, '0, '0, '0, '0, 1'b0);
    tick();
    tick();
    reset = 1'b0;

    // T1: reset values, flags cleared
    check("rst_wrap", 32'(bus0.wrap), 32'h0);
    check("rst_rd_err", 32'(bus0.rd_err), 32'h0);
    check("rst_wr_err", 32'(bus0.wr_err), 32'h0);
    for (int i = 0; i < int'(RC); i++) begin
      read_chk($sformatf("rst_reg%0d", i), i, (i == 8) ? 12'd900 : (i == 9) ? 12'd1600 : 12'd0);
    end
    drive('0, '0, '0, '0, '0, 1'b0);
    #1;
    check("idle_default", 32'(bus0.dataout), 32'd900);

    // T2: write then read; bypass instance shows datain in the same cycle
    drive(bit_of(3), bit_of(3), '0, '0, 12'hABC, 1'b0);
    #1;
    check("nobypass_same_cycle", 32'(bus0.dataout), 32'h0);
    check("bypass_same_cycle", 32'(bus1.dataout), 32'hABC);
    tick();
    read_chk("wr_rd_reg3", 3, 12'hABC);

    // T3: increment through all-ones to zero with a one-cycle wrap pulse
    drive('0, bit_of(4), '0, '0, 12'hFFE, 1'b0);
    tick();
    drive(bit_of(4), '0, bit_of(4), '0, '0, 1'b0);
    #1;
    check("inc_start", 32'(bus0.dataout), 32'hFFE);
    tick();
    check("inc_fff", 32'(bus0.dataout), 32'hFFF);
    check("inc_no_wrap", 32'(bus0.wrap), 32'h0);
    tick();
    check("inc_000", 32'(bus0.dataout), 32'h000);
    check("wrap_pulse", 32'(bus0.wrap), 32'(bit_of(4)));
    drive(bit_of(4), '0, '0, '0, '0, 1'b0);
    tick();
    check("wrap_gone", 32'(bus0.wrap), 32'h0);
    check("inc_hold", 32'(bus0.dataout), 32'h000);

    // T4: clear beats write beats increment
    drive('0, bit_of(5), '0, '0, 12'd7, 1'b0);
    tick();
    read_chk("prio_init", 5, 12'd7);
    drive(bit_of(5), bit_of(5), bit_of(5), bit_of(5), 12'd99, 1'b0);
    tick();
    check("prio_clr", 32'(bus0.dataout), 32'd0);
    drive(bit_of(5), bit_of(5), bit_of(5), '0, 12'd20, 1'b0);
    tick();
    check("prio_wr", 32'(bus0.dataout), 32'd20);
    check("prio_wrap", 32'(bus0.wrap), 32'h0);

    // Write pre-empting an increment of an all-ones register must not pulse wrap
    drive('0, bit_of(6), '0, '0, 12'hFFF, 1'b0);
    tick();
    drive('0, bit_of(6), bit_of(6), '0, 12'd3, 1'b0);
    tick();
    check("preempt_wrap", 32'(bus0.wrap), 32'h0);
    read_chk("preempt_val", 6, 12'd3);

    // T5: multi-hot write writes the lowest index and flags wr_err
    drive('0, bit_of(1) | bit_of(2), '0, '0, 12'd55, 1'b0);
    tick();
    check("wr_err_set", 32'(bus0.wr_err), 32'h1);
    check("wr_err_rd_clean", 32'(bus0.rd_err), 32'h0);
    read_chk("multi_wr_reg1", 1, 12'd55);
    read_chk("multi_wr_reg2", 2, 12'd0);
    drive(bit_of(0) | bit_of(1), '0, '0, '0, '0, 1'b0);
    #1;
    check("multi_rd_default", 32'(bus0.dataout), 32'd900);
    check("multi_rd_default_byp", 32'(bus1.dataout), 32'd900);
    tick();
    check("rd_err_set", 32'(bus0.rd_err), 32'h1);
    drive('0, '0, '0, '0, '0, 1'b1);
    tick();
    check("err_clr_rd", 32'(bus0.rd_err), 32'h0);
    check("err_clr_wr", 32'(bus0.wr_err), 32'h0);
    drive(bit_of(0) | bit_of(1), '0, '0, '0, '0, 1'b1);
    tick();
    check("set_wins_rd", 32'(bus0.rd_err), 32'h1);
    check("set_wins_wr", 32'(bus0.wr_err), 32'h0);
    drive('0, '0, '0, '0, '0, 1'b1);
    tick();

    // Independent simultaneous increments
    drive('0, '0, bit_of(0) | bit_of(1), '0, '0, 1'b0);
    tick();
    read_chk("indep_inc0", 0, 12'd1);
    read_chk("indep_inc1", 1, 12'd56);

    // T6: reset at the same edge as a wrapping increment
    drive('0, bit_of(4), '0, '0, 12'hFFF, 1'b0);
    tick();
    drive('0, '0, bit_of(4), '0, '0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    drive('0, '0, '0, '0, '0, 1'b0);
    check("midrst_wrap", 32'(bus0.wrap), 32'h0);
    read_chk("midrst_reg4", 4, 12'd0);
    read_chk("midrst_reg1", 1, 12'd0);
    read_chk("midrst_reg9", 9, 12'd1600);
    tick();
    check("midrst_wrap_later", 32'(bus0.wrap), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
